uart_rx_ascii: RTL and testbench
================================

// Module: uart_rx_ascii
// PURPOSE
//   UART receiver, 8N1, LSB first; receive-side counterpart of the button-driven ASCII transmitter.
//   Oversamples i_rxd at OVERSAMPLE x baud and re-times it with a 2-FF synchronizer.
//   Validates start and stop bits, presents each good byte with a 1-cycle o_rx_valid strobe.
//   Feeds ASCII consumers (echo/display logic) at top level, on the same clk/reset as the TX path.
// PARAMETERS
//   CLK_FREQ    100_000_000  system clock frequency, Hz
//   BAUD        9600         line rate, bit/s
//   OVERSAMPLE  16           ticks per bit period; even, >= 8
//   (derived) DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer-truncated; 651 at defaults; must be >= 2
// PORTS
//   clk          in   1  system clock, rising edge
//   reset        in   1  asynchronous, active-high; clears all state
//   i_rxd        in   1  serial line, asynchronous, idle high
//   o_rx_data    out  8  last correctly framed byte; held until next good byte
//   o_rx_valid   out  1  1-cycle strobe, o_rx_data updated the same cycle
//   o_frame_err  out  1  1-cycle strobe, stop bit sampled low
//   o_busy       out  1  high in any state other than IDLE
// BEHAVIOUR
//   - Reset values: o_rx_data=8'h00, o_rx_valid=0, o_frame_err=0, o_busy=0, sync FFs=1, state=IDLE.
//   - Reset is honoured mid-frame: the partial byte is discarded and outputs are not strobed.
//   - Tick: 1-cycle pulse every DIV clocks. The counter clears to 0 on the IDLE->START transition,
//     so the first tick comes DIV clocks after the falling edge.
//   - Sample counter s counts ticks 0..OVERSAMPLE-1 within each bit. Bit counter n runs 0..7.
//   - rxd_s = synchronized i_rxd (2-cycle latency); all decisions use rxd_s.
//   - FSM states: IDLE, START, DATA, STOP, BREAK.
//     IDLE : rxd_s==0 -> START; clear s and the tick counter.
//     START: at s==OVERSAMPLE/2-1 (mid start bit), sample.
//            sample==0 -> DATA with s=0, n=0.
//            sample==1 -> IDLE (glitch rejected, no strobe).
//     DATA : at s==OVERSAMPLE-1, shift the sample into sh[7] (right shift, so LSB first).
//            n==7 -> STOP.
//     STOP : at s==OVERSAMPLE-1, sample.
//            sample==1 -> o_rx_data<=sh, o_rx_valid=1, then IDLE.
//            sample==0 -> o_frame_err=1, o_rx_data unchanged, then BREAK.
//     BREAK: stays until rxd_s==1, then IDLE. A held-low line produces exactly one o_frame_err.
//   - All samples fall at mid-bit. A new start bit is accepted on the first clock after
//     returning to IDLE (back-to-back frames, no idle gap needed).
//   - Latency: o_rx_valid fires about 9.5 bit periods + 3 clk after the start-bit falling edge.
//   - o_rx_valid and o_frame_err are never high together.
//   - i_rxd held high indefinitely: the block stays in IDLE with no strobes.
// CONFIGURATION
//   UART_RX_MAJORITY_EN defined:
//     - Each bit value (start, data, stop) is the 2-of-3 majority of samples taken at
//       mid-1, mid and mid+1 ticks.
//     - Isolated 1-tick line glitches are rejected.
//     - Decision timing is unchanged: the result is registered at the mid+1 tick.
//   UART_RX_MAJORITY_EN undefined:
//     - Each bit value is the single sample at the mid-bit tick.
//     - The majority logic and its sample registers are not synthesized.
// STRUCTURE
//   - Shared package uart_pkg holds:
//     - the typedef for the FSM state enum (IDLE/START/DATA/STOP/BREAK), shared with the TX FSM encoding style;
//     - the constant function calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
//     - the DATA_BITS=8 localparam.
//   - One sub-module, uart_baud_tick: parameter DIV; ports clk, reset, i_clear, o_tick.
//     It is reusable by the transmitter with OVERSAMPLE=1.
//   - Synchronizer, FSM, s/n counters, shift register and majority logic stay in this module.
// TESTING
//   Bench parameters: CLK_FREQ=1_600_000, BAUD=10_000, OVERSAMPLE=16, giving DIV=10 and 160 clk per bit.
//   1. Send 0x41 ('A') 8N1 -> one o_rx_valid pulse, o_rx_data=8'h41, o_frame_err stays 0.
//   2. Send 0x55 then 0xAA back-to-back with no idle gap -> two valid pulses, data 8'h55 then 8'hAA.
//   3. Pull i_rxd low for 40 clk, then high -> no strobes; o_busy returns to 0 within about 100 clk.
//   4. Send 0x33 with the stop bit low, hold low for 2000 clk, then release and send 0x0D
//      -> exactly one o_frame_err, no valid for 0x33; then valid with 8'h0D.
//      o_rx_data keeps its prior value until then.
//   5. Assert reset during data bit 4 of 0x7E -> all outputs 0 the same cycle, no strobe.
//      After release, the next frame 0x31 is received correctly.
//   6. UART_RX_MAJORITY_EN defined: 1-clk high glitch at mid-bit of a 0 data bit in 0x00
//      -> o_rx_data=8'h00. Same stimulus with the macro undefined -> bit corrupted (8'h04 when the glitch is on bit 2).

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Definitions shared by the UART receive and transmit paths:
//               the FSM state encoding, the data width and the baud divider.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Character width on the line (8N1 framing)
  localparam int DATA_BITS = 8;

  // Frame FSM states; the transmitter uses the same encoding style
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  // Clocks per oversample tick, truncated toward zero
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Free-running divider producing a 1-cycle tick every DIV
//               clocks. i_clear restarts the count so the first tick after
//               the clear arrives DIV clocks later.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  // Count 0..DIV-1 and wrap; a clear forces the count back to zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (i_clear || (cnt_q == CNT_LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_tick = (cnt_q == CNT_LAST) && !i_clear;

endmodule : uart_baud_tick
`default_nettype wire

// File: rtl/uart_rx_ascii.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ascii
// Description : 8N1 UART receiver, LSB first, oversampled at OVERSAMPLE x
//               baud. Validates start and stop bits, strobes o_rx_valid for
//               each good byte and o_frame_err once per bad stop bit.
//               Optional macro UART_RX_MAJORITY_EN: each bit is the 2-of-3
//               vote of samples at mid-1, mid and mid+1 ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ascii
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int NW  = $clog2(DATA_BITS);

  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
  // The vote completes one tick after mid-bit, so the start decision moves out by one
  localparam logic [SW-1:0] S_START = SW'(OVERSAMPLE / 2);
`else
  localparam logic [SW-1:0] S_START = SW'(OVERSAMPLE / 2 - 1);
`endif

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 rxd_s;
  logic                 tick;
  logic                 tick_clear;
  logic                 bit_val;
  logic [SW-1:0]        s_dec;
  uart_state_e          state_q;
  logic [SW-1:0]        s_q;
  logic [NW-1:0]        n_q;
  logic [DATA_BITS-1:0] sh_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 busy_q;

  // Re-time the asynchronous line; idle level is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_rxd;
      sync2_q <= sync1_q;
    end
  end

  assign rxd_s = sync2_q;

  // Hold the tick phase at zero while idle so bit timing starts at the falling edge
  assign tick_clear = (state_q == ST_IDLE);

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk     (clk),
    .reset   (reset),
    .i_clear (tick_clear),
    .o_tick  (tick)
  );

  // Sample count at which the current bit is decided
  assign s_dec = (state_q == ST_START) ? S_START : S_LAST;

`ifdef UART_RX_MAJORITY_EN
  logic          maj0_q;
  logic          maj1_q;
  logic [SW-1:0] s_m0;
  logic [SW-1:0] s_m1;

  assign s_m0 = s_dec - SW'(2);
  assign s_m1 = s_dec - SW'(1);

  // Capture the two samples that precede the deciding tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      maj0_q <= 1'b1;
      maj1_q <= 1'b1;
    end else if (tick && (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP)) begin
      if (s_q == s_m0) maj0_q <= rxd_s;
      if (s_q == s_m1) maj1_q <= rxd_s;
    end
  end

  assign bit_val = (maj0_q & maj1_q) | (maj0_q & rxd_s) | (maj1_q & rxd_s);
`else
  assign bit_val = rxd_s;
`endif

  // Frame FSM with its counters, shift register and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!rxd_s) begin
            state_q <= ST_START;
            s_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            if (s_q == s_dec) begin
              if (!bit_val) begin
                state_q <= ST_DATA;
                s_q     <= '0;
                n_q     <= '0;
              end else begin
                // Low pulse shorter than half a bit: not a start bit
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (s_q == s_dec) begin
              sh_q <= {bit_val, sh_q[DATA_BITS-1:1]};
              s_q  <= '0;
              if (n_q == N_LAST) begin
                state_q <= ST_STOP;
              end else begin
                n_q <= n_q + 1'b1;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (s_q == s_dec) begin
              if (bit_val) begin
                data_q  <= sh_q;
                valid_q <= 1'b1;
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end else begin
                ferr_q  <= 1'b1;
                state_q <= ST_BREAK;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        ST_BREAK: begin
          // Wait out a held-low line so it reports only one framing error
          if (rxd_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_rx_data   = data_q;
  assign o_rx_valid  = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = busy_q;

endmodule : uart_rx_ascii
`default_nettype wire

// File: tb/tb_uart_rx_ascii.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ascii
// Description : Self-checking bench for uart_rx_ascii. Frames are driven
//               bit by bit; a scoreboard of expected bytes and framing
//               errors is built from the frames sent.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ascii;

  localparam int CLK_FREQ   = 1_600_000;
  localparam int BAUD       = 10_000;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLKS   = CLK_FREQ / BAUD;
`ifdef UART_RX_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       i_rxd;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_frame_err;
  logic       o_busy;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         ferr_cnt  = 0;
  int         both_cnt  = 0;
  int         hold_viol = 0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] last_good = 8'h00;

  uart_rx_ascii #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_rxd       (i_rxd),
    .o_rx_data   (o_rx_data),
    .o_rx_valid  (o_rx_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  // Observe strobes away from the active edge
  always @(negedge clk) begin
    if (reset) begin
      prev_data = 8'h00;
    end else begin
      if (o_rx_valid) got_q.push_back(o_rx_data);
      if (o_frame_err) ferr_cnt++;
      if (o_rx_valid && o_frame_err) both_cnt++;
      if (!o_rx_valid && (o_rx_data !== prev_data)) hold_viol++;
      prev_data = o_rx_data;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: the byte the receiver should report, given an optional one-clock glitch at mid-bit
  function automatic logic [7:0] model_byte(input logic [7:0] b, input int glitch);
    logic [7:0] r;
    r = b;
    if (glitch >= 0 && glitch < 8 && !MAJ) r[glitch] = ~r[glitch];
    return r;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one 8N1 frame; glitch>=0 inverts that data bit for one clock at its middle
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int glitch);
    i_rxd = 1'b0;
    wait_clks(BIT_CLKS);
    for (int j = 0; j < 8; j++) begin
      i_rxd = b[j];
      if (j == glitch) begin
        wait_clks(BIT_CLKS / 2);
        i_rxd = ~b[j];
        wait_clks(1);
        i_rxd = b[j];
        wait_clks(BIT_CLKS / 2 - 1);
      end else begin
        wait_clks(BIT_CLKS);
      end
    end
    i_rxd = stop_v;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_good(input logic [7:0] b, input int glitch);
    send_frame(b, 1'b1, glitch);
    exp_q.push_back(model_byte(b, glitch));
    last_good = model_byte(b, glitch);
  endtask

  // Compare observed strobes against the expectations accumulated since the last call
  task automatic check_scoreboard(input string tag, input int exp_ferr);
    check_eq($sformatf("%s_nvalid", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("%s_data%0d", tag, i), {24'h0, got_q[i]}, {24'h0, exp_q[i]});
    check_eq($sformatf("%s_ferr", tag), ferr_cnt, exp_ferr);
    got_q.delete();
    exp_q.delete();
    ferr_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    int         g;
    int         nferr;
    bit         bad;

    reset = 1'b1;
    i_rxd = 1'b1;
    wait_clks(5);
    check_eq("rst_data",  {24'h0, o_rx_data}, 32'h0);
    check_eq("rst_valid", {31'h0, o_rx_valid}, 32'h0);
    check_eq("rst_ferr",  {31'h0, o_frame_err}, 32'h0);
    check_eq("rst_busy",  {31'h0, o_busy}, 32'h0);
    reset = 1'b0;
    wait_clks(20);
    check_eq("idle_busy", {31'h0, o_busy}, 32'h0);
    check_scoreboard("idle", 0);

    // Single character
    send_good(8'h41, -1);
    wait_clks(50);
    check_eq("A_busy", {31'h0, o_busy}, 32'h0);
    check_scoreboard("A", 0);

    // Back-to-back frames without idle gap
    send_good(8'h55, -1);
    send_good(8'hAA, -1);
    wait_clks(50);
    check_scoreboard("b2b", 0);

    // Short low pulse is not a start bit
    i_rxd = 1'b0;
    wait_clks(30);
    check_eq("glitch_busy_hi", {31'h0, o_busy}, 32'h1);
    wait_clks(10);
    i_rxd = 1'b1;
    wait_clks(80);
    check_eq("glitch_busy_lo", {31'h0, o_busy}, 32'h0);
    check_scoreboard("glitch", 0);

    // Bad stop bit, line held low, then recovery
    send_frame(8'h33, 1'b0, -1);
    wait_clks(2000 - BIT_CLKS);
    check_eq("break_busy", {31'h0, o_busy}, 32'h1);
    check_eq("break_hold", {24'h0, o_rx_data}, {24'h0, last_good});
    i_rxd = 1'b1;
    wait_clks(50);
    check_eq("break_idle", {31'h0, o_busy}, 32'h0);
    send_good(8'h0D, -1);
    wait_clks(50);
    check_scoreboard("ferr", 1);

    // Reset in the middle of data bit 4 of 0x7E
    b = 8'h7E;
    i_rxd = 1'b0;
    wait_clks(BIT_CLKS);
    for (int j = 0; j < 4; j++) begin
      i_rxd = b[j];
      wait_clks(BIT_CLKS);
    end
    i_rxd = b[4];
    wait_clks(BIT_CLKS / 2);
    check_eq("mid_busy", {31'h0, o_busy}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check_eq("mrst_data",  {24'h0, o_rx_data}, 32'h0);
    check_eq("mrst_valid", {31'h0, o_rx_valid}, 32'h0);
    check_eq("mrst_ferr",  {31'h0, o_frame_err}, 32'h0);
    check_eq("mrst_busy",  {31'h0, o_busy}, 32'h0);
    wait_clks(3);
    i_rxd = 1'b1;
    reset = 1'b0;
    last_good = 8'h00;
    wait_clks(BIT_CLKS * 6);
    check_scoreboard("mrst", 0);
    send_good(8'h31, -1);
    wait_clks(50);
    check_scoreboard("after_rst", 0);

    // One-clock high glitch on data bit 2 of 0x00
    send_good(8'h00, 2);
    wait_clks(50);
    check_eq("glitch_byte", {24'h0, o_rx_data}, MAJ ? 32'h00 : 32'h04);
    check_scoreboard("midglitch", 0);

    // Randomized frames: mixed gaps, glitches and framing errors
    nferr = 0;
    for (int i = 0; i < 12; i++) begin
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 4) == 0);
      g   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
      if (bad) begin
        send_frame(b, 1'b0, g);
        nferr++;
        wait_clks(int'($urandom_range(0, 300)));
        i_rxd = 1'b1;
        wait_clks(int'($urandom_range(5, 200)));
      end else begin
        send_good(b, g);
        wait_clks(int'($urandom_range(0, 200)));
      end
    end
    wait_clks(50);
    check_scoreboard("rand", nferr);

    check_eq("never_both", both_cnt, 0);
    check_eq("data_held", hold_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_uart_rx_ascii
`default_nettype wire
